// File: rtl/add_arbiter_pkg.sv
// Shared types and defaults for the round-robin shared-adder arbiter.
package add_arbiter_pkg;

  localparam int DEF_NREQ  = 4;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNTW  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/add_unit.sv
// Registered WIDTH-bit adder; result {carry, sum} loads when load is high.
module add_unit
  import add_arbiter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  logic [WIDTH:0] res_q, res_d;

  always_comb begin
    res_d = res_q;
    if (load) res_d = {1'b0, a} + {1'b0, b};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) res_q <= '0;
    else        res_q <= res_d;
  end

  assign {carry, sum} = res_q;

endmodule

// File: rtl/add_arbiter.sv
// Round-robin arbiter sharing one registered adder among NREQ requesters;
// one op in flight, tagged response returned on a single channel.
module add_arbiter
  import add_arbiter_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNTW  = DEF_CNTW
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*WIDTH-1:0]  req_a,
  input  logic [NREQ*WIDTH-1:0]  req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [clog2(NREQ)-1:0] rsp_id,
  output logic [WIDTH-1:0]       rsp_data,
  output logic                   rsp_carry,
  output logic                   busy,
  output logic [CNTW-1:0]        ops_count
);

  localparam int IDW = clog2(NREQ);

  state_e           state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [CNTW-1:0]  ops_q, ops_d;
  logic [IDW-1:0]   grant, cand;
  logic             found, load;

  // Rotating priority search: first valid requester at or after rr_ptr.
  always_comb begin
    found = 1'b0;
    grant = '0;
    cand  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = IDW'((32'(rr_ptr_q) + i) % NREQ);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        grant = cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    id_d      = id_q;
    a_d       = a_q;
    b_d       = b_q;
    ops_d     = ops_q;
    req_ready = '0;
    rsp_valid = 1'b0;
    load      = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          req_ready[grant] = 1'b1;
          a_d      = req_a[grant*WIDTH +: WIDTH];
          b_d      = req_b[grant*WIDTH +: WIDTH];
          id_d     = grant;
          rr_ptr_d = IDW'((32'(grant) + 32'd1) % NREQ);
          state_d  = EXEC;
        end
      end
      EXEC: begin
        load    = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          ops_d   = ops_q + 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      id_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      ops_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      a_q      <= a_d;
      b_q      <= b_d;
      ops_q    <= ops_d;
    end
  end

  add_unit #(.WIDTH(WIDTH)) u_add (
    .clk   (clock),
    .rst_n (reset),
    .load  (load),
    .a     (a_q),
    .b     (b_q),
    .sum   (rsp_data),
    .carry (rsp_carry)
  );

  assign rsp_id    = id_q;
  assign busy      = (state_q != IDLE);
  assign ops_count = ops_q;

endmodule

// File: tb/tb_add_arbiter.sv
// Directed and randomized checks of add_arbiter against a behavioural model.
module tb_add_arbiter;

  logic        clock;
  logic        reset;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_data;
  logic        rsp_carry;
  logic        busy;
  logic [3:0]  ops_count;

  int total;
  int bad;
  int m_ptr;
  int m_ops;

  add_arbiter #(.NREQ(4), .WIDTH(8), .CNTW(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_carry (rsp_carry),
    .busy      (busy),
    .ops_count (ops_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Round-robin rule: rotate the request mask so rr_ptr sits at bit 0,
  // the lowest set bit is the winner.
  function automatic int pick(input logic [3:0] v, input int ptr);
    logic [7:0] dbl;
    dbl = {v, v} >> ptr;
    for (int j = 0; j < 4; j++)
      if (dbl[j]) return (ptr + j) % 4;
    return -1;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, req_ready, 0);
    chk({tag, "_valid"}, rsp_valid, 0);
    chk({tag, "_id"},    rsp_id, 0);
    chk({tag, "_data"},  rsp_data, 0);
    chk({tag, "_carry"}, rsp_carry, 0);
    chk({tag, "_busy"},  busy, 0);
    chk({tag, "_ops"},   ops_count, 0);
  endtask

  // Starts in an IDLE cycle at (edge + 1); returns at (edge + 2) of the
  // IDLE cycle following the response handshake.
  task automatic run_op(input logic [3:0] vmask, input logic [31:0] a_all,
                        input logic [31:0] b_all, input int stall);
    int g;
    int s;
    req_valid = vmask;
    req_a     = a_all;
    req_b     = b_all;
    rsp_ready = (stall == 0);
    #1;
    g = pick(vmask, m_ptr);
    s = int'(a_all[g*8 +: 8]) + int'(b_all[g*8 +: 8]);
    chk("grant", req_ready, 32'(1) << g);
    chk("idle_busy", busy, 0);
    @(posedge clock);
    m_ptr = (g + 1) % 4;
    #1;
    req_valid = '0;
    req_a     = $urandom;
    req_b     = $urandom;
    #1;
    chk("exec_ready", req_ready, 0);
    chk("exec_busy", busy, 1);
    chk("exec_valid", rsp_valid, 0);
    @(posedge clock);
    #2;
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_busy", busy, 1);
    chk("rsp_id", rsp_id, g);
    chk("rsp_data", rsp_data, s % 256);
    chk("rsp_carry", rsp_carry, s / 256);
    for (int k = 0; k < stall; k++) begin
      req_valid = '1;
      @(posedge clock);
      #2;
      chk("hold_valid", rsp_valid, 1);
      chk("hold_data", rsp_data, s % 256);
      chk("hold_id", rsp_id, g);
      chk("hold_ready", req_ready, 0);
      chk("hold_busy", busy, 1);
      chk("hold_ops", ops_count, m_ops % 16);
    end
    rsp_ready = 1'b1;
    @(posedge clock);
    m_ops = m_ops + 1;
    #1;
    req_valid = '0;
    rsp_ready = 1'b0;
    #1;
    chk("done_valid", rsp_valid, 0);
    chk("done_busy", busy, 0);
    chk("done_ops", ops_count, m_ops % 16);
  endtask

  task automatic idle_cycles(input int n);
    req_valid = '0;
    for (int k = 0; k < n; k++) begin
      @(posedge clock);
      #2;
      chk("idle_ready", req_ready, 0);
      chk("idle_busy", busy, 0);
      chk("idle_valid", rsp_valid, 0);
    end
  endtask

  task automatic reset_pulse();
    @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    chk_all_zero("rst");
    @(posedge clock);
    #1;
    reset = 1'b1;
    m_ptr = 0;
    m_ops = 0;
    #1;
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    m_ptr     = 0;
    m_ops     = 0;
    reset     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    #2;
    chk_all_zero("por");
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    #1;

    // Single request, no carry.
    run_op(4'b0001, 32'h0000_0012, 32'h0000_0034, 0);
    // Overflow on requester 2.
    run_op(4'b0100, 32'h00F0_0000, 32'h0020_0000, 0);
    idle_cycles(3);
    // Backpressure for 5 cycles.
    run_op(4'b1111, $urandom, $urandom, 5);

    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 2));
      run_op(4'($urandom_range(1, 15)), $urandom, $urandom, $urandom_range(0, 3));
    end
    run_op(4'b0001, 32'h0000_0011, 32'h0000_0022, 0);

    // Reset while an op from requester 1 is in EXEC.
    req_valid = 4'b0010;
    rsp_ready = 1'b1;
    @(posedge clock);
    #1;
    reset     = 1'b0;
    req_valid = '0;
    #1;
    chk_all_zero("midrst");
    for (int k = 0; k < 2; k++) begin
      @(posedge clock);
      #2;
      chk("midrst_hold_valid", rsp_valid, 0);
    end
    @(posedge clock);
    #1;
    reset = 1'b1;
    rsp_ready = 1'b0;
    m_ptr = 0;
    m_ops = 0;
    #1;
    idle_cycles(3);
    run_op(4'b1010, $urandom, $urandom, 0);
    run_op(4'b1000, $urandom, $urandom, 0);

    // Fairness from a fresh pointer, then continue to 17 ops for wrap.
    reset_pulse();
    for (int n = 0; n < 8; n++) run_op(4'b1111, $urandom, $urandom, 0);
    for (int n = 0; n < 9; n++) run_op(4'($urandom_range(1, 15)), $urandom, $urandom, 0);
    chk("wrap_ops", ops_count, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
